// File: rtl/game_controller.sv
// Asteroid-game sequencer: login, menu, intro, play, round-pass, game-over.
// Define GC_DIFFICULTY_WRAP_EN to make difficulty wrap 3->0 instead of saturating.
module game_controller #(
  parameter int COUNT_SECS = 5
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Authenticated,
  input  logic       GameStartBtn,
  input  logic       LogOutBtn,
  input  logic       CrashDetected,
  input  logic       LEDTrackerTimeOut,
  input  logic       OneSecPulse,
  output logic       NewGamePulse,
  output logic       PassedRoundPulse,
  output logic       GameOverPulse,
  output logic       EnableGameElements,
  output logic [1:0] Difficulty,
  output logic       LogOutPulse,
  output logic       EnableTimer,
  output logic [2:0] Mode
);

  typedef enum logic [2:0] {
    S_LOGGED_OUT = 3'd0,
    S_MENU       = 3'd1,
    S_INTRO      = 3'd2,
    S_WAIT_START = 3'd3,
    S_PLAY       = 3'd4,
    S_ROUND_PASS = 3'd5,
    S_GAME_OVER  = 3'd6,
    S_UNUSED     = 3'd7
  } state_t;

  localparam logic [2:0] LAST = 3'(COUNT_SECS - 1);

  state_t     r_state, w_nstate;
  logic [2:0] r_count, w_ncount;
  logic [1:0] r_diff, w_ndiff;
  logic       r_start_q, r_logout_q;
  logic       r_ng, r_pr, r_go, r_lo, r_en_game, r_en_timer;
  logic       w_ng, w_pr, w_go, w_lo;
  logic       w_start_edge, w_logout_edge, w_tick, w_done;

  always_comb begin
    w_start_edge  = GameStartBtn & ~r_start_q;
    w_logout_edge = LogOutBtn & ~r_logout_q;
    w_tick        = OneSecPulse & r_en_timer;
    w_done        = w_tick && (r_count == LAST);
    w_nstate      = r_state;
    w_ndiff       = r_diff;
    w_ncount      = w_tick ? r_count + 3'd1 : r_count;
    w_ng          = 1'b0;
    w_pr          = 1'b0;
    w_go          = 1'b0;
    w_lo          = 1'b0;
    if (r_state != S_LOGGED_OUT && !Authenticated) begin
      w_nstate = S_LOGGED_OUT;
      w_ndiff  = 2'd0;
    end else if (r_state != S_LOGGED_OUT && w_logout_edge) begin
      w_nstate = S_LOGGED_OUT;
      w_ndiff  = 2'd0;
      w_lo     = 1'b1;
    end else begin
      case (r_state)
        S_LOGGED_OUT:
          if (Authenticated) w_nstate = S_MENU;
        S_MENU:
          if (w_start_edge) begin
            w_nstate = S_INTRO;
            w_ng     = 1'b1;
            w_ndiff  = 2'd0;
            w_ncount = 3'd0;
          end
        S_INTRO:
          if (w_done) w_nstate = S_WAIT_START;
        S_WAIT_START:
          if (w_start_edge) w_nstate = S_PLAY;
        S_PLAY:
          if (CrashDetected) begin
            w_nstate = S_GAME_OVER;
            w_go     = 1'b1;
            w_ncount = 3'd0;
          end else if (LEDTrackerTimeOut) begin
            w_nstate = S_ROUND_PASS;
            w_pr     = 1'b1;
            w_ncount = 3'd0;
`ifdef GC_DIFFICULTY_WRAP_EN
            w_ndiff  = r_diff + 2'd1;
`else
            w_ndiff  = (r_diff == 2'd3) ? 2'd3
                                        : r_diff + 2'd1;
`endif
          end
        S_ROUND_PASS:
          if (w_done) w_nstate = S_WAIT_START;
        S_GAME_OVER:
          if (w_done) w_nstate = S_MENU;
        default:
          w_nstate = S_LOGGED_OUT;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= S_LOGGED_OUT;
      r_count    <= 3'd0;
      r_diff     <= 2'd0;
      r_start_q  <= 1'b0;
      r_logout_q <= 1'b0;
      r_ng       <= 1'b0;
      r_pr       <= 1'b0;
      r_go       <= 1'b0;
      r_lo       <= 1'b0;
      r_en_game  <= 1'b0;
      r_en_timer <= 1'b0;
    end else begin
      r_state    <= w_nstate;
      r_count    <= w_ncount;
      r_diff     <= w_ndiff;
      r_start_q  <= GameStartBtn;
      r_logout_q <= LogOutBtn;
      r_ng       <= w_ng;
      r_pr       <= w_pr;
      r_go       <= w_go;
      r_lo       <= w_lo;
      r_en_game  <= (w_nstate == S_PLAY);
      r_en_timer <= (w_nstate == S_INTRO) ||
                    (w_nstate == S_ROUND_PASS) ||
                    (w_nstate == S_GAME_OVER);
    end
  end

  assign Mode               = r_state;
  assign Difficulty         = r_diff;
  assign NewGamePulse       = r_ng;
  assign PassedRoundPulse   = r_pr;
  assign GameOverPulse      = r_go;
  assign LogOutPulse        = r_lo;
  assign EnableGameElements = r_en_game;
  assign EnableTimer        = r_en_timer;

endmodule

// File: tb/tb_game_controller.sv
// Scoreboard bench for game_controller: directed scenarios then random
// stimulus, every cycle checked against a ticks-remaining reference model.
module tb_game_controller;
  localparam int COUNT = 5;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic Authenticated = 1'b0;
  logic GameStartBtn = 1'b0;
  logic LogOutBtn = 1'b0;
  logic CrashDetected = 1'b0;
  logic LEDTrackerTimeOut = 1'b0;
  logic OneSecPulse = 1'b0;
  logic NewGamePulse, PassedRoundPulse, GameOverPulse;
  logic EnableGameElements, LogOutPulse, EnableTimer;
  logic [1:0] Difficulty;
  logic [2:0] Mode;

  int n_cmp = 0;
  int n_bad = 0;
  logic [10:0] q[$];

  int m_mode, m_diff, m_left;
  bit m_sq, m_lq;

  always #5 Clk = ~Clk;

  game_controller #(.COUNT_SECS(COUNT)) dut (
    .Clk(Clk), .Reset(Reset),
    .Authenticated(Authenticated),
    .GameStartBtn(GameStartBtn),
    .LogOutBtn(LogOutBtn),
    .CrashDetected(CrashDetected),
    .LEDTrackerTimeOut(LEDTrackerTimeOut),
    .OneSecPulse(OneSecPulse),
    .NewGamePulse(NewGamePulse),
    .PassedRoundPulse(PassedRoundPulse),
    .GameOverPulse(GameOverPulse),
    .EnableGameElements(EnableGameElements),
    .Difficulty(Difficulty),
    .LogOutPulse(LogOutPulse),
    .EnableTimer(EnableTimer),
    .Mode(Mode)
  );

  function automatic void model_reset();
    m_mode = 0;
    m_diff = 0;
    m_left = 0;
    m_sq = 1'b0;
    m_lq = 1'b0;
  endfunction

  // Model tracks seconds still to wait; result packs the expected outputs.
  function automatic logic [10:0] model_step(
    bit a, bit s, bit l, bit c, bit t, bit k);
    bit se, le;
    bit ng = 0, pr = 0, gv = 0, lo = 0;
    se = s && !m_sq;
    le = l && !m_lq;
    m_sq = s;
    m_lq = l;
    if (m_mode != 0 && !a) begin
      m_mode = 0; m_diff = 0;
    end else if (m_mode != 0 && le) begin
      m_mode = 0; m_diff = 0; lo = 1;
    end else begin
      case (m_mode)
        0: if (a) m_mode = 1;
        1: if (se) begin
          m_mode = 2; ng = 1; m_diff = 0; m_left = COUNT;
        end
        2, 5, 6: if (k) begin
          m_left = m_left - 1;
          if (m_left == 0) m_mode = (m_mode == 6) ? 1 : 3;
        end
        3: if (se) m_mode = 4;
        4: if (c) begin
          m_mode = 6; gv = 1; m_left = COUNT;
        end else if (t) begin
          m_mode = 5; pr = 1; m_left = COUNT;
`ifdef GC_DIFFICULTY_WRAP_EN
          m_diff = (m_diff + 1) % 4;
`else
          m_diff = (m_diff < 3) ? m_diff + 1 : 3;
`endif
        end
        default: m_mode = 0;
      endcase
    end
    return {3'(m_mode), 2'(m_diff), ng, pr, gv, lo,
            m_mode == 4, m_mode inside {2, 5, 6}};
  endfunction

  task automatic go(bit a, bit s, bit l, bit c,
                    bit t, bit k, int n = 1);
    repeat (n) begin
      @(negedge Clk);
      Authenticated     = a;
      GameStartBtn      = s;
      LogOutBtn         = l;
      CrashDetected     = c;
      LEDTrackerTimeOut = t;
      OneSecPulse       = k;
      q.push_back(model_step(a, s, l, c, t, k));
    end
  endtask

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  // Monitor: outputs are presented every cycle, one expectation per cycle.
  initial begin
    logic [10:0] e, a;
    forever begin
      @(posedge Clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        a = {Mode, Difficulty, NewGamePulse, PassedRoundPulse,
             GameOverPulse, LogOutPulse, EnableGameElements,
             EnableTimer};
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL outputs @%0t: got {mode,diff,ng,pr,go,lo,eg,et}=%b required %b",
                   $time, a, e);
        end
      end
    end
  end

  task automatic to_play_from_wait();
    go(1, 1, 0, 0, 0, 0);
    go(1, 0, 0, 0, 0, 0);
  endtask

  task automatic pass_round();
    go(1, 0, 0, 0, 1, 0);
    go(1, 0, 0, 0, 0, 1, COUNT);
    to_play_from_wait();
  endtask

  initial begin
    model_reset();
    #2;
    chk("reset_mode", Mode, 0);
    chk("reset_diff", Difficulty, 0);
    chk("reset_en", {EnableGameElements, EnableTimer}, 0);
    chk("reset_pulses", {NewGamePulse, PassedRoundPulse,
        GameOverPulse, LogOutPulse}, 0);
    @(negedge Clk);
    Reset = 1'b0;

    go(1, 0, 0, 0, 0, 0, 2);
    go(1, 1, 0, 0, 0, 0);
    go(1, 0, 0, 0, 0, 0);
    go(1, 0, 0, 0, 0, 1, COUNT);
    to_play_from_wait();
    pass_round();
    go(1, 0, 0, 1, 1, 0);
    go(1, 0, 0, 0, 0, 1, COUNT);
    go(1, 1, 0, 0, 0, 1);
    go(1, 0, 0, 0, 0, 1, COUNT);
    to_play_from_wait();
    repeat (4) pass_round();
    go(1, 0, 0, 0, 1, 0);
    go(1, 0, 0, 0, 0, 1, COUNT);
    go(1, 1, 0, 0, 0, 0, 10);
    go(1, 0, 0, 0, 0, 0);
    go(1, 0, 0, 1, 0, 0);
    go(1, 0, 1, 0, 0, 0);
    go(1, 0, 0, 0, 0, 0, 2);
    go(1, 1, 0, 0, 0, 0);
    go(1, 0, 0, 0, 0, 1, COUNT);
    to_play_from_wait();
    go(0, 0, 0, 0, 0, 0);
    go(1, 0, 0, 0, 0, 0);
    go(1, 1, 0, 0, 0, 0);
    go(1, 0, 0, 0, 0, 1, COUNT);
    to_play_from_wait();
    pass_round();
    @(posedge Clk);
    #3;
    Reset = 1'b1;
    #1;
    chk("async_mode", Mode, 0);
    chk("async_eg", EnableGameElements, 0);
    chk("async_diff", Difficulty, 0);
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    model_reset();

    repeat (3000) begin
      go($urandom_range(0, 99) != 0,
         $urandom_range(0, 3) == 0,
         $urandom_range(0, 199) == 0,
         $urandom_range(0, 15) == 0,
         $urandom_range(0, 7) == 0,
         $urandom_range(0, 2) == 0);
    end

    repeat (3) @(negedge Clk);
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
